// File: rtl/systolic_pkg.sv
// systolic_pkg
//   Definitions shared by the systolic array and its processing elements:
//   FP16 field positions, the hidden-bit constant, default widths and the
//   weight-precision clamp helper.
package systolic_pkg;

  localparam int DEF_ACT_WIDTH = 16;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_N         = 2;

  localparam int EXP_WIDTH  = 5;
  localparam int PREC_WIDTH = 4;

  // FP16 field layout
  localparam int FP16_SIGN    = 15;
  localparam int FP16_EXP_MSB = 14;
  localparam int FP16_EXP_LSB = 10;
  localparam int FP16_MAN_MSB = 9;
  localparam int FP16_MAN_LSB = 0;

  localparam logic HIDDEN_BIT = 1'b1;

  // A weight needs at least a sign bit and one magnitude bit.
  localparam logic [PREC_WIDTH-1:0] PREC_MIN = 4'd2;
  localparam int                    PREC_MAX = 15;

  function automatic logic [PREC_WIDTH-1:0] clamp_prec(input logic [PREC_WIDTH-1:0] p);
    if (p < PREC_MIN) begin
      clamp_prec = PREC_MIN;
    end else begin
      clamp_prec = p;
    end
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe
//   One bit-serial FP16 x INT multiply-accumulate cell.
//   A window of P edges starts when enable is high and the cell is idle.
//   First edge: align the FP16 activation to exp_set and latch the weight
//   sign bit. Next P-1 edges: shift-add magnitude bits MSB first. The last
//   edge adds or subtracts the product into the accumulator.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : row enable (already skewed by the top level)
//   prec       : clamped weight precision P
//   exp_set    : shared exponent the activation is aligned to
//   act        : FP16 activation (live)
//   w_bit      : bit-serial weight (live)
//   busy       : a window is in progress
//   exp_out    : exponent tag loaded at window start
//   acc_out    : two's-complement accumulator
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PREC_WIDTH-1:0] prec,
  input  logic [EXP_WIDTH-1:0]  exp_set,
  input  logic [ACT_WIDTH-1:0]  act,
  input  logic                  w_bit,
  output logic                  busy,
  output logic [EXP_WIDTH-1:0]  exp_out,
  output logic [ACC_WIDTH-1:0]  acc_out
);

  logic                  busy_r;
  logic [PREC_WIDTH-1:0] cnt_r;
  logic [PREC_WIDTH-1:0] p_r;
  logic                  sign_r;
  logic [ACC_WIDTH-1:0]  a_r;
  logic [ACC_WIDTH-1:0]  m_r;
  logic [ACC_WIDTH-1:0]  acc_r;
  logic [EXP_WIDTH-1:0]  exp_r;

  logic [ACC_WIDTH-1:0]  a_s;
  logic [ACC_WIDTH-1:0]  m_next_s;
  logic                  last_s;

  // Align {1,mantissa} to exp_set; shift right truncates, exponent 0 is zero.
  function automatic logic [ACC_WIDTH-1:0] align_act(input logic [ACT_WIDTH-1:0] a,
                                                    input logic [EXP_WIDTH-1:0] e_ref);
    logic [EXP_WIDTH-1:0] e;
    logic [EXP_WIDTH:0]   up;
    logic [EXP_WIDTH:0]   dn;
    logic [ACC_WIDTH-1:0] sig;
    logic [ACC_WIDTH-1:0] mag;
    e   = a[FP16_EXP_MSB:FP16_EXP_LSB];
    up  = {1'b0, e} - {1'b0, e_ref};
    dn  = {1'b0, e_ref} - {1'b0, e};
    sig = {ACC_WIDTH{1'b0}};
    sig[FP16_MAN_MSB+1:0] = {HIDDEN_BIT, a[FP16_MAN_MSB:FP16_MAN_LSB]};
    if (e == {EXP_WIDTH{1'b0}}) begin
      mag = {ACC_WIDTH{1'b0}};
    end else if (e >= e_ref) begin
      mag = sig << up;
    end else begin
      mag = sig >> dn;
    end
    if (a[FP16_SIGN]) begin
      align_act = -mag;
    end else begin
      align_act = mag;
    end
  endfunction

  // Aligner, serial shift-add step and last-edge detect.
  always_comb begin
    a_s      = align_act(act, exp_set);
    m_next_s = {m_r[ACC_WIDTH-2:0], 1'b0} + (w_bit ? a_r : {ACC_WIDTH{1'b0}});
    last_s   = (cnt_r == (p_r - 4'd1));
  end

  // Window counter, partial sum and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      cnt_r  <= 4'd0;
      p_r    <= PREC_MIN;
      sign_r <= 1'b0;
      a_r    <= {ACC_WIDTH{1'b0}};
      m_r    <= {ACC_WIDTH{1'b0}};
      acc_r  <= {ACC_WIDTH{1'b0}};
      exp_r  <= {EXP_WIDTH{1'b0}};
    end else if (busy_r) begin
      if (last_s) begin
        // Sign-magnitude weight: subtract when the sign bit was 1.
        acc_r  <= sign_r ? (acc_r - m_next_s) : (acc_r + m_next_s);
        m_r    <= {ACC_WIDTH{1'b0}};
        cnt_r  <= 4'd0;
        busy_r <= 1'b0;
      end else begin
        m_r   <= m_next_s;
        cnt_r <= cnt_r + 4'd1;
      end
    end else if (enable) begin
      busy_r <= 1'b1;
      cnt_r  <= 4'd1;
      p_r    <= prec;
      sign_r <= w_bit;
      a_r    <= a_s;
      m_r    <= {ACC_WIDTH{1'b0}};
      exp_r  <= exp_set;
    end
  end

  assign busy    = busy_r;
  assign exp_out = exp_r;
  assign acc_out = acc_r;

endmodule

// File: rtl/systolic.sv
// systolic
//   N x N array of bit-serial FP16 x INT MAC cells. Row r receives the
//   stream-valid signal delayed by r*P cycles; activations and weights are
//   taken live. done pulses once after the last row finishes and the array
//   has gone quiet.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   active     : stream-valid for row 0
//   precision  : weight bit-width P (values below 2 act as 2)
//   exp_set    : shared alignment exponent
//   act_in[r]  : FP16 activation for row r
//   w_in[c]    : bit-serial weight for column c
//   done       : one-cycle completion pulse
//   exp_out[i] : per-PE exponent tag, i = r*N+c
//   acc_out[i] : per-PE accumulator, i = r*N+c
module systolic
  import systolic_pkg::*;
#(
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int N         = DEF_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic [PREC_WIDTH-1:0] precision,
  input  logic [EXP_WIDTH-1:0]  exp_set,
  input  logic [ACT_WIDTH-1:0]  act_in [N],
  input  logic                  w_in [N],
  output logic                  done,
  output logic [EXP_WIDTH-1:0]  exp_out [N*N],
  output logic [ACC_WIDTH-1:0]  acc_out [N*N]
);

  // Delay line long enough for the deepest row at the largest precision.
  localparam int DL = (N > 1) ? (N - 1) * PREC_MAX : 2;

  logic [DL-1:0]         dly_r;
  logic                  busy_last_r;
  logic                  done_r;

  logic [PREC_WIDTH-1:0] prec_s;
  logic                  row_en_s [N];
  logic                  busy_s [N*N];
  logic                  any_en_s;
  logic                  any_busy_s;
  logic                  commit_s;

  // Row enables: row 0 is live, row r taps the delay line at r*P-1.
  always_comb begin
    prec_s      = clamp_prec(precision);
    row_en_s[0] = active;
    for (int r = 1; r < N; r++) begin
      row_en_s[r] = dly_r[r * int'(prec_s) - 1];
    end
  end

  // Quiet detection; the last row's busy falling edge marks its commit,
  // since only reset can end a window early and reset clears this too.
  always_comb begin
    any_en_s   = 1'b0;
    any_busy_s = 1'b0;
    for (int r = 0; r < N; r++) begin
      any_en_s = any_en_s | row_en_s[r];
    end
    for (int i = 0; i < N * N; i++) begin
      any_busy_s = any_busy_s | busy_s[i];
    end
    commit_s = busy_last_r & ~busy_s[(N-1)*N];
  end

  // Enable skew line, last-row busy history and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_r       <= {DL{1'b0}};
      busy_last_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      dly_r       <= {dly_r[DL-2:0], active};
      busy_last_r <= busy_s[(N-1)*N];
      done_r      <= commit_s & ~any_en_s & ~any_busy_s;
    end
  end

  assign done = done_r;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      systolic_pe #(
        .ACT_WIDTH(ACT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
      ) u_pe (
        .clk    (clk),
        .rst    (rst),
        .enable (row_en_s[r]),
        .prec   (prec_s),
        .exp_set(exp_set),
        .act    (act_in[r]),
        .w_bit  (w_in[c]),
        .busy   (busy_s[r*N+c]),
        .exp_out(exp_out[r*N+c]),
        .acc_out(acc_out[r*N+c])
      );
    end
  end

endmodule

// File: tb/tb_systolic.sv
// tb_systolic
//   Directed vectors with hand-computed accumulator, exponent and done
//   expectations for a 2x2 array.
module tb_systolic;

  localparam int ACT_WIDTH = 16;
  localparam int ACC_WIDTH = 32;
  localparam int N         = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 active;
  logic [3:0]           precision;
  logic [4:0]           exp_set;
  logic [ACT_WIDTH-1:0] act_in [N];
  logic                 w_in [N];
  logic                 done;
  logic [4:0]           exp_out [N*N];
  logic [ACC_WIDTH-1:0] acc_out [N*N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic #(.ACT_WIDTH(ACT_WIDTH), .ACC_WIDTH(ACC_WIDTH), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .precision(precision),
    .exp_set  (exp_set),
    .act_in   (act_in),
    .w_in     (w_in),
    .done     (done),
    .exp_out  (exp_out),
    .acc_out  (acc_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < N * N; i++) begin
      check_eq($sformatf("%s_acc%0d", tag, i), acc_out[i], 32'h0);
      check_eq($sformatf("%s_exp%0d", tag, i), {27'd0, exp_out[i]}, 32'h0);
    end
    check_eq($sformatf("%s_done", tag), {31'd0, done}, 32'h0);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    active    = 1'b0;
    act_in[0] = 16'h0000;
    act_in[1] = 16'h0000;
    w_in[0]   = 1'b0;
    w_in[1]   = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;
  endtask

  // One window per row: row 0 takes a0 at edge 0, row 1 takes a1 at edge p.
  // Weight patterns are p bits, sign first, repeated for both rows.
  task automatic run_window(input string name, input bit do_rst,
                            input logic [3:0] prec_in, input int p, input logic [4:0] es,
                            input logic [15:0] a0, input logic [15:0] a1,
                            input logic [14:0] w0, input logic [14:0] w1, input int act_len,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input logic [4:0] eexp);
    int pulses;
    int at;
    logic [31:0] exp_acc [N*N];
    exp_acc[0] = e0;
    exp_acc[1] = e1;
    exp_acc[2] = e2;
    exp_acc[3] = e3;
    if (do_rst) apply_reset();
    precision = prec_in;
    exp_set   = es;
    pulses    = 0;
    at        = -1;
    for (int k = 0; k < 2 * p + 8; k++) begin
      active    = (k < act_len);
      act_in[0] = (k == 0) ? a0 : 16'h0000;
      act_in[1] = (k == p) ? a1 : 16'h0000;
      w_in[0]   = (k < 2 * p) ? w0[p - 1 - (k % p)] : 1'b0;
      w_in[1]   = (k < 2 * p) ? w1[p - 1 - (k % p)] : 1'b0;
      step();
      if (done) begin
        pulses++;
        at = k;
      end
    end
    check_eq({name, "_done_pulses"}, pulses, 32'd1);
    check_eq({name, "_done_cycle"}, at, 2 * p);
    for (int i = 0; i < N * N; i++) begin
      check_eq($sformatf("%s_acc%0d", name, i), acc_out[i], exp_acc[i]);
      check_eq($sformatf("%s_exp%0d", name, i), {27'd0, exp_out[i]}, {27'd0, eexp});
    end
  endtask

  // Two-burst scenario; optionally reset during row 1's second window.
  task automatic run_main(input bit interrupt);
    int pulses;
    int at;
    int last_k;
    apply_reset();
    precision = 4'd4;
    exp_set   = 5'd15;
    w_in[0]   = 1'b1;
    w_in[1]   = 1'b1;
    pulses    = 0;
    at        = -1;
    last_k    = interrupt ? 10 : 20;
    for (int k = 0; k < last_k; k++) begin
      active    = (k < 8);
      act_in[0] = (k < 4) ? 16'h3C00 : ((k < 8) ? 16'h4200 : 16'h0000);
      act_in[1] = (k < 8) ? 16'h4000 : 16'h3C00;
      step();
      if (done) begin
        pulses++;
        at = k;
      end
    end
    if (interrupt) begin
      check_eq("mid_row0_acc", acc_out[0], 32'hFFFF9000);
      check_eq("mid_row1_acc", acc_out[2], 32'hFFFFC800);
      rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      active = 1'b0;
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (done) pulses++;
      end
      check_eq("mid_rst_no_done", pulses, 32'd0);
    end else begin
      check_eq("main_done_pulses", pulses, 32'd1);
      check_eq("main_done_cycle", at, 32'd12);
      check_eq("main_acc0", acc_out[0], 32'hFFFF9000);
      check_eq("main_acc1", acc_out[1], 32'hFFFF9000);
      check_eq("main_acc2", acc_out[2], 32'hFFFFAC00);
      check_eq("main_acc3", acc_out[3], 32'hFFFFAC00);
      for (int i = 0; i < N * N; i++) begin
        check_eq($sformatf("main_exp%0d", i), {27'd0, exp_out[i]}, 32'd15);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    active    = 1'b0;
    precision = 4'd4;
    exp_set   = 5'd15;
    act_in[0] = 16'h0000;
    act_in[1] = 16'h0000;
    w_in[0]   = 1'b0;
    w_in[1]   = 1'b0;

    run_main(1'b0);
    run_main(1'b1);
    run_main(1'b0);

    // +7 / +1 weights on 1.0 and -1.0; active held 2 cycles.
    run_window("s1", 1'b1, 4'd4, 4, 5'd15, 16'h3C00, 16'hBC00, 15'b0111, 15'b0001, 2,
               32'h00001C00, 32'h00000400, 32'hFFFFE400, 32'hFFFFFC00, 5'd15);
    // Zero activation leaves the accumulators unchanged.
    run_window("s2", 1'b0, 4'd4, 4, 5'd15, 16'h0000, 16'h0000, 15'b1111, 15'b0101, 2,
               32'h00001C00, 32'h00000400, 32'hFFFFE400, 32'hFFFFFC00, 5'd15);
    // Second burst accumulates on top of the first.
    run_window("s3", 1'b0, 4'd4, 4, 5'd15, 16'h4200, 16'h4000, 15'b1001, 15'b0010, 1,
               32'h00001000, 32'h00001C00, 32'hFFFFDC00, 32'h00000C00, 5'd15);
    // Precision 1 acts as 2; right-shift alignment truncates.
    run_window("s4", 1'b1, 4'd1, 2, 5'd15, 16'h3801, 16'h3400, 15'b01, 15'b11, 1,
               32'h00000200, 32'hFFFFFE00, 32'h00000100, 32'hFFFFFF00, 5'd15);
    // P=3 with exp_set 14: left-shift alignment.
    run_window("s5", 1'b1, 4'd3, 3, 5'd14, 16'h3C00, 16'h4A00, 15'b011, 15'b110, 1,
               32'h00001800, 32'hFFFFF000, 32'h00012000, 32'hFFFF4000, 5'd14);
    // Large shift wraps in the accumulator width.
    run_window("s6", 1'b1, 4'd2, 2, 5'd0, 16'h7BFF, 16'h0000, 15'b01, 15'b11, 1,
               32'hC0000000, 32'h40000000, 32'h00000000, 32'h00000000, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic.md
SYSTOLIC -- requirements
Module: systolic

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ACT_WIDTH, 16, FP16 activation width; ACC_WIDTH, 32, accumulator width; N, 2, array is N x N PEs.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 active  input  1  stream-valid; high while row-0 activation windows are fed.
REQ-005 precision  input  4  weight bit-width P (sign + P-1 magnitude bits); values below 2 SHALL be treated as 2.
REQ-006 exp_set  input  5  shared FP16 exponent that accumulators are aligned to.
REQ-007 act_in  input  N x ACT_WIDTH (unpacked)  FP16 activation per row r.
REQ-008 w_in  input  N x 1 (unpacked)  bit-serial weight per column c.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 exp_out  output  N*N x 5  per-PE exponent tag, index r*N+c.
REQ-011 acc_out  output  N*N x ACC_WIDTH  per-PE two's-complement accumulator, index r*N+c.

Function
REQ-012 Row enable SHALL be active delayed by r*P cycles (row 0 undelayed); act_in and w_in SHALL be sampled live, without delay.
REQ-013 Each row SHALL start a P-cycle window on an edge where its enable is high and no window is in progress; a started window SHALL always run all P cycles, even if enable drops.
REQ-014 At the window's first edge, each PE[r][c] SHALL sample act_in[r] and w_in[c] (sign bit); on the following P-1 edges it SHALL sample w_in[c] magnitude bits, MSB first.
REQ-015 Aligned activation SHALL be A = {1,mantissa} shifted left by (exp - exp_set) when positive and right (truncating) when negative, negated if the FP16 sign is set; exp==0 SHALL give A=0.
REQ-016 Magnitude SHALL accumulate serially as m = 2*m + bit*A; on the window's P-th edge acc SHALL update to acc + m, or acc - m when the weight sign is 1 (sign-magnitude weight).
REQ-017 Arithmetic SHALL be ACC_WIDTH two's complement with silent wrap-around.
REQ-018 exp_out SHALL load exp_set at every window start.
REQ-019 All columns of a row SHALL operate in lockstep; PE[r][c] differs only by w_in[c].
REQ-020 done SHALL pulse high for one cycle on the edge after row N-1 commits its last window, provided no row enable is high and no window is in progress.
REQ-021 An active rise SHALL NOT clear accumulators; results accumulate across bursts until reset.

Reset
REQ-022 rst high SHALL asynchronously clear all acc_out, exp_out, done, delay lines, window counters and partial sums to 0, including mid-window; no commit SHALL occur for an interrupted window.

Structure
REQ-023 A shared package SHALL hold the FP16 field positions (sign 15, exponent 14:10, mantissa 9:0), hidden-bit constant and default widths.
REQ-024 One sub-module systolic_pe (bit-serial FP-INT MAC: aligner, shift-add, accumulator, window counter) SHALL be instantiated N*N times; enable-skew delay lines belong in the top level.

Verification
REQ-025 P=4, exp_set=15, all w_in=1; act_in[0]=1.0 (3C00) for 4 cycles then 3.0 (4200) for 4 cycles, then 0; act_in[1]=2.0 (4000) for 8 cycles then 1.0 (3C00); active high 8 cycles -> acc_out[0],[1]=FFFF9000; acc_out[2],[3]=FFFFAC00; exp_out all 15; done pulses once.
REQ-026 P=4, exp_set=15, one window, act 1.0, weight bits 0,1,1,1 (+7) -> acc 00001C00.
REQ-027 P=4, act -1.0 (BC00), weight bits 0,0,0,1 -> acc FFFFFC00; act 0000 with any weight -> acc unchanged.
REQ-028 exp_set=15, act 0.5 (3800), weight +1 (P=2, bits 0,1) -> acc 00000200.
REQ-029 Assert rst during row 1's second window -> all outputs 0 immediately, no done pulse; a fresh scenario after deassert reproduces REQ-025 results.
REQ-030 active dropped after 2 cycles with P=4 -> each row still completes one full window, and done pulses exactly once, the cycle after row N-1 commits.
